// File: rtl/distro_ram_wdec.sv
// rtl/distro_ram_wdec.sv - one-hot write-enable decoder for distro_ram
module distro_ram_wdec #(
  parameter int LOG_DEP = 3,
  parameter int DEPTH   = 2**LOG_DEP
) (
  input  logic               wen,
  input  logic [LOG_DEP-1:0] addr,
  output logic [DEPTH-1:0]   we
);

  always_comb begin
    we = '0;
    if (wen) begin
      we[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/distro_ram.sv
// rtl/distro_ram.sv - single-port distributed RAM, synchronous write, combinational read
module distro_ram #(
  parameter int WIDTH   = 8,
  parameter int LOG_DEP = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wen,
  input  logic [LOG_DEP-1:0] addr,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout
);

  localparam int DEPTH = 2**LOG_DEP;

  logic [DEPTH-1:0] we;
  logic [WIDTH-1:0] rd [DEPTH];

  distro_ram_wdec #(
    .LOG_DEP (LOG_DEP),
    .DEPTH   (DEPTH)
  ) u_wdec (
    .wen  (wen),
    .addr (addr),
    .we   (we)
  );

  // Each entry owns its register so only the decoded word can change on an edge.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [WIDTH-1:0] word;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        word <= '0;
      end else if (we[i]) begin
        word <= din;
      end
    end

    assign rd[i] = word;
  end

  assign dout = rd[addr];

endmodule

// File: tb/tb_distro_ram.sv
// tb/tb_distro_ram.sv - directed self-checking bench for distro_ram
module tb_distro_ram;

  logic       clock;
  logic       reset_n;
  logic       wen;
  logic [2:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  int compared;
  int mismatched;

  logic [7:0] model [8];

  distro_ram #(
    .WIDTH   (8),
    .LOG_DEP (3)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wen     (wen),
    .addr    (addr),
    .din     (din),
    .dout    (dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got 0x%02h want 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clock);
    wen  = 1'b1;
    addr = a;
    din  = d;
    @(posedge clock);
    #1;
    chk($sformatf("wr_visible@%0d", a), dout, d);
    model[a] = d;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      #1;
      chk($sformatf("%s@%0d", tag, i), dout, model[i]);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;

    // reset held; a write attempt during reset must be discarded
    reset_n = 1'b0;
    wen     = 1'b1;
    addr    = 3'd4;
    din     = 8'hAA;
    repeat (2) @(posedge clock);
    @(negedge clock);
    wen = 1'b0;
    sweep("in_reset");

    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    sweep("post_reset");

    // fill
    wr(3'd0, 8'hCA);
    wr(3'd2, 8'hBE);
    wr(3'd5, 8'hDF);
    wr(3'd1, 8'hEA);
    wr(3'd4, 8'h99);
    wr(3'd3, 8'h80);
    @(negedge clock);
    wen  = 1'b0;
    addr = 3'd2;
    #1;
    chk("fill_read2", dout, 8'hBE);

    // complete fill
    wr(3'd7, 8'h35);
    wr(3'd6, 8'h22);
    @(negedge clock);
    wen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] want;
      case (i)
        0: want = 8'hCA; 1: want = 8'hEA; 2: want = 8'hBE; 3: want = 8'h80;
        4: want = 8'h99; 5: want = 8'hDF; 6: want = 8'h22; default: want = 8'h35;
      endcase
      addr = 3'(i);
      #1;
      chk($sformatf("full_read@%0d", i), dout, want);
    end

    // write disabled: din ignored across all addresses
    din = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      addr = 3'(i);
      @(posedge clock);
      #1;
      chk($sformatf("wen0@%0d", i), dout, model[i]);
    end
    @(negedge clock);
    sweep("wen0_sweep");

    // read-during-write same address: old word before edge, new word after
    @(negedge clock);
    addr = 3'd3;
    wen  = 1'b1;
    din  = 8'h5A;
    #1;
    chk("rdw_before", dout, 8'h80);
    @(posedge clock);
    #1;
    chk("rdw_after", dout, 8'h5A);
    model[3] = 8'h5A;
    @(negedge clock);
    wen = 1'b0;
    sweep("rdw_others");

    // async reset mid-cycle
    @(negedge clock);
    addr = 3'd0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_now", dout, 8'h00);
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    // write edge while reset held is discarded
    wen  = 1'b1;
    din  = 8'h77;
    @(posedge clock);
    #1;
    chk("rst_write_blocked", dout, 8'h00);
    @(negedge clock);
    wen     = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    sweep("after_async_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
